jkff_ctrl: RTL and testbench
============================

JKFF_CTRL -- requirements
Module: jkff_ctrl

Interface
REQ-001 Parameter POR_VALUE, default 1, power-on/reset value of the driven JK flop and of out_mirror.
REQ-002 Parameter LEN_W, default 8, width of the pulse-length field.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_op  input  2  00 HOLD, 01 SET, 10 CLR, 11 TOG.
REQ-008 cmd_len  input  LEN_W  0 = single excitation; N>0 = pulse of N hold cycles, then restore.
REQ-009 cmd_abort  input  1  terminate an active pulse early.
REQ-010 j  output  1  registered J drive to the external JK flop.
REQ-011 k  output  1  registered K drive to the external JK flop.
REQ-012 out_mirror  output  1  tracked value of the driven flop.
REQ-013 done  output  1  one-cycle pulse marking a command's final excitation cycle.

Function
REQ-014 FSM states IDLE, APPLY, HOLD, RESTORE; cmd_ready SHALL be 1 exactly in IDLE.
REQ-015 Accept at edge ending cycle T -> APPLY during T+1; j/k SHALL carry the op excitation: SET j=1 k=0; CLR j=0 k=1; TOG j=1 k=1; HOLD j=0 k=0.
REQ-016 In all states other than APPLY and RESTORE, j=0 and k=0.
REQ-017 In APPLY, the pre-command out_mirror value SHALL be saved as restore value.
REQ-018 APPLY with len=0: done=1 in APPLY, next state IDLE; earliest next accept at edge ending T+2.
REQ-019 APPLY with len=N>0: next state HOLD, down-counter loaded with N; HOLD lasts exactly N cycles, then RESTORE.
REQ-020 RESTORE lasts one cycle, done=1; TOG restores with j=1 k=1; SET/CLR drive the saved value (j=1 k=0 or j=0 k=1), or j=k=0 if saved value equals current; HOLD drives j=k=0; next state IDLE.
REQ-021 cmd_abort sampled only in HOLD: at that edge next state RESTORE regardless of remaining count; ignored in IDLE, APPLY, RESTORE.
REQ-022 out_mirror SHALL follow JK semantics on j/k each edge (11 toggle, 10 set, 01 clear, 00 hold); visible one cycle after the excitation cycle.
REQ-023 cmd_len=2^LEN_W-1 SHALL produce exactly that many HOLD cycles; counter SHALL never wrap.
REQ-024 cmd_op/cmd_len SHALL be registered at accept; changes while not ready have no effect.

Reset
REQ-025 rst asserted SHALL immediately force state IDLE, j=0, k=0, done=0, counter=0, out_mirror=POR_VALUE[0], including mid-pulse.
REQ-026 First accept possible at first rising edge with rst low.

Structure
REQ-027 Package jkff_ctrl_pkg SHALL hold the op enum (HOLD/SET/CLR/TOG) and the FSM state enum.
REQ-028 out_mirror SHALL be produced by one instance of jkff_ar (POR_VALUE passed through) fed by j, k, clk, rst.

Verification
REQ-029 POR_VALUE=0, reset release, SET len=0 -> j=1 k=0 for one cycle, done=1 same cycle, out_mirror=1 next cycle, cmd_ready=1 cycle after.
REQ-030 out_mirror=0, TOG len=3 -> APPLY j=k=1, 3 cycles j=k=0 with out_mirror=1, RESTORE j=k=1 done=1, out_mirror=0 after; total 5 cycles accept-to-IDLE.
REQ-031 out_mirror=1, SET len=2 -> APPLY j=1 k=0, 2 HOLD cycles, RESTORE j=k=0, out_mirror stays 1.
REQ-032 CLR len=200, cmd_abort pulsed in 5th HOLD cycle -> RESTORE next cycle j=1 k=0, done=1, out_mirror back to 1.
REQ-033 rst asserted in HOLD of TOG len=10 -> j=k=0, done=0, out_mirror=POR_VALUE immediately; cmd_ready=1 after release.
REQ-034 cmd_valid held high with back-to-back SET/CLR/TOG len=0 -> accepts every 2nd cycle, out_mirror sequence 1,0,1.

Source files
------------

// File: rtl/jkff_ctrl_pkg.sv
// Shared types for the JK flop command controller: command opcodes, FSM
// states and the opcode-to-excitation mapping.
package jkff_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_TOG  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RESTORE = 2'd3
  } state_e;

  // Returns {j, k} that makes a JK flop perform the given operation.
  function automatic logic [1:0] op_excite(input op_e op);
    logic [1:0] jk;
    case (op)
      OP_SET:  jk = 2'b10;
      OP_CLR:  jk = 2'b01;
      OP_TOG:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jkff_ar.sv
// JK flip-flop with asynchronous active-high reset to a configurable value.
// Used as the controller's model of the externally driven flop.
module jkff_ar #(
  parameter int POR_VALUE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK update: 11 toggle, 10 set, 01 clear, 00 hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= POR_VALUE[0];
    end else begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jkff_ctrl.sv
// Command-driven controller for an external JK flop. A command applies one
// excitation and either finishes immediately (len = 0) or holds for len
// cycles and then drives the flop back to its pre-command value.
module jkff_ctrl
  import jkff_ctrl_pkg::*;
#(
  parameter int POR_VALUE = 1,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_abort,
  output logic             j,
  output logic             k,
  output logic             out_mirror,
  output logic             done
);

  state_e           state;
  state_e           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             j_nxt;
  logic             k_nxt;
  logic             done_nxt;
  logic             accept;

  op_e              op_r;
  logic [LEN_W-1:0] len_r;
  logic             saved;
  logic [1:0]       restore_jk;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Excitation that returns the flop to its saved pre-command value.
  // SET/CLR only drive when the flop actually moved; TOG simply toggles back.
  always_comb begin
    restore_jk = 2'b00;
    case (op_r)
      OP_TOG: restore_jk = 2'b11;
      OP_SET, OP_CLR: begin
        if (saved != out_mirror) begin
          restore_jk = saved ? 2'b10 : 2'b01;
        end
      end
      default: restore_jk = 2'b00;
    endcase
  end

  // Next-state logic; j/k/done are computed one cycle ahead so they leave
  // the controller straight from flops in the cycle they belong to.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    j_nxt     = 1'b0;
    k_nxt     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt      = ST_APPLY;
          {j_nxt, k_nxt} = op_excite(op_e'(cmd_op));
          done_nxt       = (cmd_len == '0);
        end
      end
      ST_APPLY: begin
        if (len_r == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_HOLD;
          cnt_nxt   = len_r;
        end
      end
      ST_HOLD: begin
        // Counter enters HOLD at len >= 1, so it leaves at 1 and never wraps.
        if (cmd_abort || (cnt == LEN_W'(1))) begin
          state_nxt      = ST_RESTORE;
          cnt_nxt        = '0;
          {j_nxt, k_nxt} = restore_jk;
          done_nxt       = 1'b1;
        end else begin
          cnt_nxt = cnt - LEN_W'(1);
        end
      end
      ST_RESTORE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Control registers: FSM state, counter and registered flop drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
      done  <= done_nxt;
    end
  end

  // Command capture at accept and restore-value capture during APPLY, when
  // the mirror still shows the pre-command value.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= op_e'(cmd_op);
      len_r <= cmd_len;
    end
    if (state == ST_APPLY) begin
      saved <= out_mirror;
    end
  end

  jkff_ar #(
    .POR_VALUE(POR_VALUE)
  ) u_mirror (
    .clk(clk),
    .rst(rst),
    .j  (j),
    .k  (k),
    .q  (out_mirror)
  );

endmodule

// File: tb/tb_jkff_ctrl.sv
// Self-checking bench for jkff_ctrl: directed scenarios followed by random
// commands, all checked cycle by cycle against a command-level model.
module tb_jkff_ctrl;

  localparam int LEN_W = 8;
  localparam int POR   = 0;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_abort = 1'b0;
  logic             j;
  logic             k;
  logic             out_mirror;
  logic             done;

  int   checks = 0;
  int   errors = 0;
  logic m;

  jkff_ctrl #(
    .POR_VALUE(POR),
    .LEN_W    (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_abort (cmd_abort),
    .j         (j),
    .k         (k),
    .out_mirror(out_mirror),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  function automatic logic jk_apply(input logic q, input logic jj, input logic kk);
    if (jj && kk) return ~q;
    if (jj) return 1'b1;
    if (kk) return 1'b0;
    return q;
  endfunction

  // {j,k} for an opcode: 1 SET, 2 CLR, 3 TOG, 0 HOLD
  function automatic logic [1:0] exc(input int op);
    case (op)
      1:       return 2'b10;
      2:       return 2'b01;
      3:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Starts in an IDLE cycle just after a rising edge; ends just after the
  // edge that returns the controller to IDLE, with cmd_valid still high.
  task automatic run_cmd(input int op, input int len, input int abort_at, input string tag);
    logic [1:0] e;
    logic [1:0] r;
    logic [1:0] jk_exp;
    logic       d_exp;
    logic       m0;
    logic       m1;
    int         hold_n;
    int         total;
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_len   = len[LEN_W-1:0];
    cmd_abort = 1'($urandom);
    @(negedge clk);
    chk($sformatf("%s.ready_idle", tag), cmd_ready, 1'b1);
    chk($sformatf("%s.mirror_idle", tag), out_mirror, m);
    @(posedge clk);
    #1;
    e  = exc(op);
    m0 = m;
    m1 = jk_apply(m0, e[1], e[0]);
    hold_n = (len == 0) ? 0 : ((abort_at > 0) ? abort_at : len);
    case (op)
      3:       r = 2'b11;
      1, 2:    r = (m0 == m1) ? 2'b00 : (m0 ? 2'b10 : 2'b01);
      default: r = 2'b00;
    endcase
    total = (len == 0) ? 1 : hold_n + 2;
    for (int c = 0; c < total; c++) begin
      cmd_op  = 2'($urandom);
      cmd_len = LEN_W'($urandom);
      if (c == 0) begin
        jk_exp    = e;
        d_exp     = (len == 0);
        cmd_abort = 1'($urandom);
      end else if (c <= hold_n) begin
        jk_exp    = 2'b00;
        d_exp     = 1'b0;
        cmd_abort = (c == abort_at);
      end else begin
        jk_exp    = r;
        d_exp     = 1'b1;
        cmd_abort = 1'($urandom);
      end
      @(negedge clk);
      chk($sformatf("%s.j c%0d", tag, c), j, jk_exp[1]);
      chk($sformatf("%s.k c%0d", tag, c), k, jk_exp[0]);
      chk($sformatf("%s.done c%0d", tag, c), done, d_exp);
      chk($sformatf("%s.ready c%0d", tag, c), cmd_ready, 1'b0);
      chk($sformatf("%s.mirror c%0d", tag, c), out_mirror, m);
      @(posedge clk);
      #1;
      m = jk_apply(m, jk_exp[1], jk_exp[0]);
    end
    cmd_abort = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    cmd_valid = 1'b0;
    cmd_abort = 1'($urandom);
    @(negedge clk);
    chk($sformatf("%s.ready", tag), cmd_ready, 1'b1);
    chk($sformatf("%s.j", tag), j, 1'b0);
    chk($sformatf("%s.k", tag), k, 1'b0);
    chk($sformatf("%s.done", tag), done, 1'b0);
    chk($sformatf("%s.mirror", tag), out_mirror, m);
    @(posedge clk);
    #1;
    cmd_abort = 1'b0;
  endtask

  initial begin
    int op;
    int len;
    int abort_at;
    int r;
    m = POR[0];
    #1;
    rst = 1'b1;
    #1;
    chk("rst.ready", cmd_ready, 1'b1);
    chk("rst.j", j, 1'b0);
    chk("rst.k", k, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.mirror", out_mirror, POR[0]);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_cmd(1, 0, 0, "por_set");
    idle_check("por_set_after");
    run_cmd(2, 0, 0, "clr0");
    run_cmd(3, 3, 0, "tog3");
    idle_check("tog3_after");
    run_cmd(1, 0, 0, "set0");
    run_cmd(1, 2, 0, "set2");
    idle_check("set2_after");
    run_cmd(2, 200, 5, "clr_abort");
    idle_check("clr_abort_after");

    run_cmd(1, 0, 0, "b2b_set");
    run_cmd(2, 0, 0, "b2b_clr");
    run_cmd(3, 0, 0, "b2b_tog");
    idle_check("b2b_after");

    run_cmd(0, 3, 0, "hold3");
    run_cmd(3, 255, 0, "maxlen");
    idle_check("maxlen_after");

    // reset in the middle of a TOG len=10 pulse
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_len   = LEN_W'(10);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.busy", cmd_ready, 1'b0);
    chk("midrst.mirror_toggled", out_mirror, ~m);
    rst = 1'b1;
    #1;
    chk("midrst.j", j, 1'b0);
    chk("midrst.k", k, 1'b0);
    chk("midrst.done", done, 1'b0);
    chk("midrst.mirror", out_mirror, POR[0]);
    chk("midrst.ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m   = POR[0];
    idle_check("midrst_after");

    for (int i = 0; i < 25; i++) begin
      op = int'($urandom % 4);
      r  = int'($urandom % 8);
      len = (r == 7) ? int'($urandom_range(8, 40)) : r;
      abort_at = (len > 0 && ($urandom % 3) == 0) ? int'($urandom_range(1, len)) : 0;
      run_cmd(op, len, abort_at, $sformatf("rnd%0d", i));
      if (($urandom % 2) == 1) idle_check($sformatf("rnd%0d_after", i));
    end
    idle_check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
